// File: rtl/harmonic_mix_pkg.sv
// Shared types for the harmonic mix sequencer: FSM states and index-width helper.
package harmonic_mix_pkg;
  localparam int HARMONICS_MAX = 64;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_ISSUE, S_WAIT_LOW, S_WAIT_DONE, S_OUTPUT
  } state_t;

  function automatic int idx_bits_calc(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/harmonic_level_ram.sv
// Per-harmonic level table: one synchronous write port, one asynchronous read port,
// cleared by reset.
module harmonic_level_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 7,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge clock) begin
      if (reset)                                  mem[i] <= '0;
      else if (wr_en && wr_addr == AW'(i))        mem[i] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rd_addr == AW'(i)) rd_data = mem[i];
  end
endmodule

// File: rtl/harmonic_mix_sequencer.sv
// Drives the shared fractional-scaling multiplier over every harmonic of a frame and
// latches the summed mix. Optional macro HARMONIC_SKIP_ZERO_EN skips zero-level harmonics.
module harmonic_mix_sequencer
  import harmonic_mix_pkg::*;
#(
  parameter int HARMONICS    = 16,
  parameter int DIVISOR_BITS = 7,
  parameter int IDX_BITS     = idx_bits_calc(HARMONICS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic                    level_wr_en,
  input  logic [IDX_BITS-1:0]     level_wr_addr,
  input  logic [DIVISOR_BITS-1:0] level_wr_data,
  output logic                    sample_req,
  output logic [IDX_BITS-1:0]     sample_idx,
  input  logic                    sample_ack,
  input  logic [15:0]             sample_in,
  output logic                    mul_start,
  output logic                    mul_clear,
  output logic [DIVISOR_BITS-1:0] mul_multiple,
  output logic [15:0]             mul_in,
  input  logic                    mul_done,
  input  logic [31:0]             mul_acc,
  output logic [31:0]             mix_out,
  output logic                    mix_valid,
  output logic                    busy,
  output logic                    overrun
);
`ifdef HARMONIC_SKIP_ZERO_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  state_t                  state;
  logic [DIVISOR_BITS-1:0] level_rd;
  logic                    last, skip_cur;

  harmonic_level_ram #(.DEPTH(HARMONICS), .WIDTH(DIVISOR_BITS), .AW(IDX_BITS)) u_levels (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (level_wr_en),
    .wr_addr (level_wr_addr),
    .wr_data (level_wr_data),
    .rd_addr (sample_idx),
    .rd_data (level_rd)
  );

  assign last     = (sample_idx == IDX_BITS'(HARMONICS - 1));
  assign skip_cur = SKIP_ZERO && (level_rd == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      sample_idx   <= '0;
      sample_req   <= 1'b0;
      mul_start    <= 1'b0;
      mul_clear    <= 1'b0;
      mul_multiple <= '0;
      mul_in       <= '0;
      mix_out      <= '0;
      mix_valid    <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      mul_clear <= 1'b0;
      mix_valid <= 1'b0;
      // busy already covers the OUTPUT and mix_valid cycles, so one test catches every overrun
      if (frame_start && busy) overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (frame_start && !busy) begin
            state      <= S_CLEAR;
            mul_clear  <= 1'b1;
            sample_idx <= '0;
            busy       <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        S_CLEAR: begin
          state      <= S_FETCH;
          sample_req <= !SKIP_ZERO;
        end
        S_FETCH: begin
          if (skip_cur) begin
            sample_req <= 1'b0;
            if (last) state <= S_OUTPUT;
            else      sample_idx <= sample_idx + 1'b1;
          end else if (sample_req && sample_ack) begin
            sample_req   <= 1'b0;
            mul_in       <= sample_in;
            mul_multiple <= level_rd;
            mul_start    <= 1'b1;
            state        <= S_ISSUE;
          end else begin
            sample_req <= 1'b1;
          end
        end
        S_ISSUE: state <= S_WAIT_LOW;
        S_WAIT_LOW: if (!mul_done) state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (mul_done) begin
            if (last) begin
              state <= S_OUTPUT;
            end else begin
              state      <= S_FETCH;
              sample_idx <= sample_idx + 1'b1;
              sample_req <= !SKIP_ZERO;
            end
          end
        end
        // mul_acc settles as done rises, so it is sampled one cycle after WAIT_DONE
        S_OUTPUT: begin
          mix_out   <= mul_acc;
          mix_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_harmonic_mix_sequencer.sv
// Randomized self-checking bench: behavioural sample source and multiplier, frame-sum
// reference model computed from the level and sample tables.
module tb_harmonic_mix_sequencer;
  localparam int H  = 4;
  localparam int DB = 7;
  localparam int IB = 2;
`ifdef HARMONIC_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          level_wr_en = 1'b0;
  logic [IB-1:0] level_wr_addr = '0;
  logic [DB-1:0] level_wr_data = '0;
  logic          sample_req;
  logic [IB-1:0] sample_idx;
  logic          sample_ack = 1'b0;
  logic [15:0]   sample_in = '0;
  logic          mul_start, mul_clear;
  logic [DB-1:0] mul_multiple;
  logic [15:0]   mul_in;
  logic          mul_done = 1'b1;
  logic [31:0]   mul_acc = '0;
  logic [31:0]   mix_out;
  logic          mix_valid, busy, overrun;

  harmonic_mix_sequencer #(.HARMONICS(H), .DIVISOR_BITS(DB)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start),
    .level_wr_en(level_wr_en), .level_wr_addr(level_wr_addr), .level_wr_data(level_wr_data),
    .sample_req(sample_req), .sample_idx(sample_idx), .sample_ack(sample_ack),
    .sample_in(sample_in), .mul_start(mul_start), .mul_clear(mul_clear),
    .mul_multiple(mul_multiple), .mul_in(mul_in), .mul_done(mul_done), .mul_acc(mul_acc),
    .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  int n_checks = 0, n_fail = 0;
  int lvl [H];
  int samp [H];
  int delay_cfg = 1, held_last = -1, stab_err = 0, force_lat = 0;
  bit rand_delay = 1'b0;
  int last_nvalid, last_nstart, last_nbusy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sample source: acks delay_cfg cycles after it first sees a request
  int wcnt = 0, hcnt = 0;
  always @(negedge clock) begin
    sample_ack = 1'b0;
    if (reset || !sample_req) begin
      wcnt = 0; hcnt = 0;
    end else if (wcnt >= delay_cfg) begin
      sample_ack = 1'b1;
      sample_in  = 16'(samp[sample_idx]);
      held_last  = hcnt;
      wcnt = 0; hcnt = 0;
      if (rand_delay) delay_cfg = $urandom_range(1, 5);
    end else begin
      wcnt++; hcnt++;
    end
  end

  // Multiplier: done low for 2..4 cycles after start, acc += sample*level/2^DB on rise
  int mrem = 0;
  logic [15:0]   cap_in;
  logic [DB-1:0] cap_mul;
  function automatic int scale(input logic [15:0] s, input logic [DB-1:0] l);
    return (int'($signed(s)) * int'(l)) >>> DB;
  endfunction
  always @(negedge clock) begin
    if (reset) begin
      mul_done = 1'b1; mul_acc = '0; mrem = 0;
    end else begin
      if (mul_clear) mul_acc = '0;
      if (mrem > 0) begin
        if (mul_in !== cap_in || mul_multiple !== cap_mul) stab_err++;
        mrem--;
        if (mrem == 0) begin
          mul_done = 1'b1;
          mul_acc  = mul_acc + scale(cap_in, cap_mul);
        end
      end
      if (mul_start) begin
        cap_in = mul_in; cap_mul = mul_multiple; mul_done = 1'b0;
        mrem = (force_lat > 0) ? force_lat : $urandom_range(2, 4);
      end
    end
  end

  function automatic logic [31:0] ref_mix();
    int sum = 0;
    for (int h = 0; h < H; h++) begin
      int p, q;
      p = samp[h] * lvl[h];
      q = p / 128;
      if (p < 0 && (p % 128) != 0) q = q - 1;
      sum += q;
    end
    return 32'(sum);
  endfunction

  function automatic int exp_starts();
    int n = 0;
    for (int h = 0; h < H; h++) if (!SKIP || lvl[h] != 0) n++;
    return n;
  endfunction

  task automatic write_level(input int a, input int d);
    @(negedge clock);
    level_wr_en = 1'b1; level_wr_addr = IB'(a); level_wr_data = DB'(d); lvl[a] = d;
    @(negedge clock);
    level_wr_en = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check(tag, {sample_req, sample_idx, mul_start, mul_clear, mul_multiple, mul_in,
                mix_out, mix_valid, busy, overrun}, '0);
  endtask

  // mode 0 plain, 1 second frame_start mid-frame, 2 write lvl1=127 at idx0 issue,
  // 3 write lvl1=5 in idx1 issue cycle
  task automatic run_frame(input string tag, input int mode, input logic [31:0] exp);
    int nvalid = 0, nstart = 0, nbusy = 0;
    bit seen = 0, ok = 0;
    logic [31:0] got = '0;
    @(negedge clock);
    frame_start = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      frame_start = 1'b0; level_wr_en = 1'b0;
      if (mode == 1 && cyc == 5) frame_start = 1'b1;
      if (mode == 2 && mul_start && sample_idx == 0) begin
        level_wr_en = 1'b1; level_wr_addr = 1; level_wr_data = 127; lvl[1] = 127;
      end
      if (mode == 3 && mul_start && sample_idx == 1) begin
        level_wr_en = 1'b1; level_wr_addr = 1; level_wr_data = 5; lvl[1] = 5;
      end
      if (busy) nbusy++;
      if (mul_start) nstart++;
      if (mix_valid) begin nvalid++; got = mix_out; seen = 1; end
      if (seen && !busy) begin ok = 1; break; end
    end
    level_wr_en = 1'b0;
    check({tag, "_timeout"}, ok, 1'b1);
    check({tag, "_mix"}, got, exp);
    check({tag, "_nvalid"}, nvalid, 1);
    last_nvalid = nvalid; last_nstart = nstart; last_nbusy = nbusy;
  endtask

  task automatic run_reset_abort();
    int t = -1, nvalid = 0;
    bit hit = 0;
    force_lat = 3;
    @(negedge clock);
    frame_start = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clock);
      frame_start = 1'b0;
      if (mul_start && sample_idx == 2) t = cyc;
      if (t >= 0 && cyc == t + 2 && !mul_done) begin hit = 1; break; end
    end
    check("abort_reached_wait_done", hit, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    check_zero("abort_outputs_zero");
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (mix_valid) nvalid++;
    end
    check("abort_no_mix_valid", nvalid, 0);
    check("abort_idle", busy, 1'b0);
    force_lat = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e;
    int exp_len;
    for (int h = 0; h < H; h++) begin lvl[h] = 0; samp[h] = 0; end
    repeat (3) @(negedge clock);
    check_zero("reset_outputs_zero");
    reset = 1'b0;

    write_level(0, 64); write_level(1, 32); write_level(2, 0); write_level(3, 127);
    samp[0] = 1000; samp[1] = 2000; samp[2] = 3000; samp[3] = -128;
    delay_cfg = 1;
    run_frame("basic", 0, 32'd873);
    check("basic_starts", last_nstart, exp_starts());
    check("basic_held", held_last, 1);
    check("basic_busy_after", busy, 1'b0);

    delay_cfg = 7;
    run_frame("slow_ack", 0, 32'd873);
    check("slow_ack_held", held_last, 7);
    check("slow_ack_stable", stab_err, 0);
    delay_cfg = 1;

    run_frame("overrun", 1, 32'd873);
    check("overrun_set", overrun, 1'b1);
    run_frame("after_overrun", 0, 32'd873);
    check("overrun_sticky", overrun, 1'b1);

    lvl[1] = 127; e = ref_mix(); lvl[1] = 32;
    run_frame("wr_ahead", 2, e);
    e = ref_mix();
    run_frame("wr_issue_old", 3, e);
    run_frame("wr_issue_new", 0, ref_mix());

    run_reset_abort();
    check("abort_overrun_cleared", overrun, 1'b0);
    for (int h = 0; h < H; h++) lvl[h] = 0;
    force_lat = 2;
`ifdef HARMONIC_SKIP_ZERO_EN
    exp_len = 7;
`else
    exp_len = 23;
`endif
    run_frame("zero_table", 0, 32'd0);
    check("zero_table_starts", last_nstart, exp_starts());
    check("zero_table_len", last_nbusy, exp_len);
    force_lat = 0;
    write_level(0, 64); write_level(1, 32); write_level(2, 0); write_level(3, 127);
    run_frame("after_abort", 0, 32'd873);

    rand_delay = 1'b1;
    for (int f = 0; f < 8; f++) begin
      for (int h = 0; h < H; h++) begin
        write_level(h, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 127));
        samp[h] = int'($urandom_range(0, 65535)) - 32768;
      end
      run_frame("rand", 0, ref_mix());
      check("rand_starts", last_nstart, exp_starts());
    end
    check("rand_stable", stab_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
